si_header_attacher: RTL and testbench

// - Transmit-side counterpart of the receive channel's header detacher.
// - Takes a 128-bit tag stream on clk and cuts it into frames of at most MAX_PAYLOAD_BEATS beats.
// - Prepends a 2-beat header to each frame: Ethernet MAC/ethertype, version, sequence number, rollover time.
// - Output feeds the MAC TX path (MAC adds preamble/CRC).

---
 rtl/si_tx_pkg.sv | 48 ++++
 rtl/si_header_attacher_if.sv | 15 +
 rtl/si_header_attacher_chk.sv | 26 ++
 rtl/si_header_attacher.sv | 185 ++++++++++++++++++
 tb/tb_si_header_attacher.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/si_tx_pkg.sv
// Shared types and helpers for the transmit-side header attacher: FSM states,
// header beat layouts and network byte-order swaps.
package si_tx_pkg;

    localparam int unsigned TDATA_W      = 128;
    localparam int unsigned TKEEP_W      = 16;
    localparam int unsigned TUSER_W      = 32;
    localparam int unsigned HEADER_BEATS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    // Fields listed MSB first; the lowest field lands on the first wire bytes.
    typedef struct packed {
        logic [15:0] version;
        logic [15:0] ethertype;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
    } hdr0_t;

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] rollover;
        logic [63:0] pad;
    } hdr1_t;

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [47:0] bswap48(input logic [47:0] v);
        logic [47:0] r;
        r = 48'h0;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = v[8*(5-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/si_header_attacher_if.sv
// AXI-Stream style beat bus used for both the tag input and the frame output.
interface si_header_attacher_if;
    import si_tx_pkg::*;

    logic               tvalid;
    logic               tready;
    logic [TDATA_W-1:0] tdata;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/si_header_attacher_chk.sv
// Simulation checks on the tag input: byte enables must be 4-byte granular.
module si_header_attacher_chk
    import si_tx_pkg::*;
(
    input logic               clk,
    input logic               rst,
    input logic               tvalid,
    input logic [TKEEP_W-1:0] tkeep
);

    function automatic logic keep_granular(input logic [TKEEP_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < TKEEP_W / 4; i++) begin
            if ((k[4*i +: 4] != 4'h0) && (k[4*i +: 4] != 4'hF)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    a_keep_granular: assert property (@(posedge clk) disable iff (rst)
        tvalid |-> keep_granular(tkeep))
        else $error("tkeep %h is not 4-byte granular", tkeep);

endmodule

// File: rtl/si_header_attacher.sv
// Cuts the tag stream into frames of bounded length and prepends a 2-beat
// Ethernet/protocol header to each; the output is a single registered stage.
module si_header_attacher
    import si_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned KEEP_WIDTH        = 16,
    parameter int unsigned MAX_PAYLOAD_BEATS = 64,
    parameter logic [15:0] ETHERTYPE         = 16'h88B5,
    parameter logic [15:0] VERSION           = 16'h0001
) (
    input  logic                 clk,
    input  logic                 rst,
    si_header_attacher_if.slave  s_axis,
    si_header_attacher_if.master m_axis,
    input  logic [47:0]          cfg_dst_mac,
    input  logic [47:0]          cfg_src_mac,
    output logic [31:0]          sent_frames
);

    localparam int unsigned      CNT_W    = $clog2(MAX_PAYLOAD_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PAYLOAD_BEATS - 1);

    if ((DATA_WIDTH != 128) || (KEEP_WIDTH != DATA_WIDTH / 8) || (MAX_PAYLOAD_BEATS < 1)) begin : g_bad_cfg
        $error("si_header_attacher: unsupported DATA_WIDTH/KEEP_WIDTH/MAX_PAYLOAD_BEATS");
    end

    state_t             state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [TDATA_W-1:0] m_data_q, m_data_d;
    logic [TKEEP_W-1:0] m_keep_q, m_keep_d;
    logic               m_last_q, m_last_d;
    logic [31:0]        seq_q, seq_d;
    logic [31:0]        sent_q, sent_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        roll_q, roll_d;
    logic [47:0]        dst_q, dst_d;
    logic [47:0]        src_q, src_d;
    logic               out_free_s;
    logic               s_ready_s;
    logic               frame_end_s;
    hdr0_t              hdr0_s;
    hdr1_t              hdr1_s;

    assign out_free_s  = !m_valid_q || m_axis.tready;
    assign frame_end_s = s_axis.tlast || (s_axis.tkeep != {TKEEP_W{1'b1}}) || (cnt_q == LAST_CNT);

    // Header beats in wire order, each multi-byte field big-endian.
    always_comb begin
        hdr0_s.version   = bswap16(VERSION);
        hdr0_s.ethertype = bswap16(ETHERTYPE);
        hdr0_s.src_mac   = bswap48(src_q);
        hdr0_s.dst_mac   = bswap48(dst_q);
        hdr1_s.seq       = bswap32(seq_q);
        hdr1_s.rollover  = bswap32(roll_q);
        hdr1_s.pad       = 64'h0;
    end

    // Frame FSM: header sequencing, payload pass-through and output stage loading.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        roll_d    = roll_q;
        dst_d     = dst_q;
        src_d     = src_q;
        s_ready_s = 1'b0;
        if (m_valid_q && m_axis.tready && m_last_q) begin
            sent_d = sent_q + 32'd1;
        end else begin
            sent_d = sent_q;
        end
        // A drained stage goes idle unless one of the states below refills it.
        if (out_free_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (s_axis.tvalid) begin
                    roll_d  = s_axis.tuser;
                    dst_d   = cfg_dst_mac;
                    src_d   = cfg_src_mac;
                    state_d = HDR0;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR0: begin
                if (out_free_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = hdr0_s;
                    m_keep_d  = {TKEEP_W{1'b1}};
                    m_last_d  = 1'b0;
                    state_d   = HDR1;
                end else begin
                    state_d = HDR0;
                end
            end
            HDR1: begin
                if (out_free_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = hdr1_s;
                    m_keep_d  = {TKEEP_W{1'b1}};
                    m_last_d  = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = PAYLOAD;
                end else begin
                    state_d = HDR1;
                end
            end
            PAYLOAD: begin
                s_ready_s = out_free_s;
                if (out_free_s && s_axis.tvalid) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis.tdata;
                    m_keep_d  = s_axis.tkeep;
                    m_last_d  = frame_end_s;
                    if (frame_end_s) begin
                        seq_d   = seq_q + 32'd1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = PAYLOAD;
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= {TDATA_W{1'b0}};
            m_keep_q  <= {TKEEP_W{1'b0}};
            m_last_q  <= 1'b0;
            seq_q     <= 32'd0;
            sent_q    <= 32'd0;
            cnt_q     <= {CNT_W{1'b0}};
            roll_q    <= 32'd0;
            dst_q     <= 48'd0;
            src_q     <= 48'd0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            seq_q     <= seq_d;
            sent_q    <= sent_d;
            cnt_q     <= cnt_d;
            roll_q    <= roll_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
        end
    end

    assign s_axis.tready = s_ready_s;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = {TUSER_W{1'b0}};
    assign sent_frames   = sent_q;

    si_header_attacher_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .tvalid (s_axis.tvalid),
        .tkeep  (s_axis.tkeep)
    );

endmodule

// File: tb/tb_si_header_attacher.sv
// Randomised bench for si_header_attacher: a byte-level frame model predicts
// every output beat, plus fixed expectations for the directed scenarios.
module tb_si_header_attacher;
    import si_tx_pkg::*;

    localparam int          MAXB  = 64;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam logic [15:0] VER   = 16'h0001;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] cfg_dst_mac;
    logic [47:0] cfg_src_mac;
    logic [31:0] sent_frames;

    si_header_attacher_if s_axis ();
    si_header_attacher_if m_axis ();

    si_header_attacher dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_axis),
        .m_axis      (m_axis),
        .cfg_dst_mac (cfg_dst_mac),
        .cfg_src_mac (cfg_src_mac),
        .sent_frames (sent_frames)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          ready_pct  = 100;
    logic [31:0] m_seq      = 32'd0;
    int          m_cnt      = 0;
    bit          m_in_frame = 1'b0;
    int          m_frames   = 0;

    task automatic check(input bit ok, input string name, input logic [144:0] act, input logic [144:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic beat_t mk_hdr0(input logic [47:0] d, input logic [47:0] s);
        beat_t b;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b.data[8*i +: 8]     = d[8*(5-i) +: 8];
            b.data[8*(6+i) +: 8] = s[8*(5-i) +: 8];
        end
        b.data[8*12 +: 8] = ETYPE[15:8];
        b.data[8*13 +: 8] = ETYPE[7:0];
        b.data[8*14 +: 8] = VER[15:8];
        b.data[8*15 +: 8] = VER[7:0];
        b.keep = 16'hFFFF;
        return b;
    endfunction

    function automatic beat_t mk_hdr1(input logic [31:0] sq, input logic [31:0] roll);
        beat_t b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b.data[8*(8+i) +: 8]  = roll[8*(3-i) +: 8];
            b.data[8*(12+i) +: 8] = sq[8*(3-i) +: 8];
        end
        b.keep = 16'hFFFF;
        return b;
    endfunction

    // Reference model: a frame opens when payload is offered, closes on tlast, partial keep or length.
    always @(negedge clk) begin : model
        beat_t pb;
        if (!rst && s_axis.tvalid) begin
            if (!m_in_frame) begin
                exp_q.push_back(mk_hdr0(cfg_dst_mac, cfg_src_mac));
                exp_q.push_back(mk_hdr1(m_seq, s_axis.tuser));
                m_in_frame = 1'b1;
                m_cnt      = 0;
            end
            if (s_axis.tready) begin
                pb.data = s_axis.tdata;
                pb.keep = s_axis.tkeep;
                pb.last = s_axis.tlast || (s_axis.tkeep != 16'hFFFF) || (m_cnt == MAXB - 1);
                exp_q.push_back(pb);
                if (pb.last) begin
                    m_seq      = m_seq + 32'd1;
                    m_in_frame = 1'b0;
                    m_frames++;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis.tready = ($urandom_range(99) < ready_pct);
    end

    // Output compare: every handshaken beat against the model, and hold-while-stalled.
    always @(negedge clk) begin : compare
        beat_t cur;
        beat_t e;
        beat_t prev_b;
        bit    prev_stall;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {m_axis.tdata, m_axis.tkeep, m_axis.tlast};
            if (prev_stall) begin
                check(m_axis.tvalid && (cur == prev_b), "stall_hold", cur, prev_b);
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", cur, '0);
                end else begin
                    e = exp_q.pop_front();
                    check(cur == e, "beat", cur, e);
                end
                got_q.push_back(cur);
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_b     = cur;
        end
    end

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input bit l, input logic [31:0] u);
        bit done;
        int waited;
        done   = 1'b0;
        waited = 0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        while (!done && waited < 2000) begin
            @(negedge clk);
            if (s_axis.tready) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) check(1'b0, "send_timeout", 145'(waited), 145'd2000);
        s_axis.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int keep_idx, input logic [15:0] keep_val,
                              input bit last_at_end, input logic [31:0] user0, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) repeat ($urandom_range(gap)) begin @(posedge clk); #1; end
            send_beat({$urandom(), $urandom(), $urandom(), $urandom()},
                      (i == keep_idx) ? keep_val : 16'hFFFF,
                      last_at_end && (i == n - 1),
                      (i == 0) ? user0 : $urandom());
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_axis.tvalid || m_in_frame) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(t < 3000, "drain_timeout", 145'(t), 145'd3000);
        check(sent_frames == 32'(m_frames), "sent_frames", 145'(sent_frames), 145'(m_frames));
    endtask

    function automatic logic [31:0] seq_field(input int idx);
        if (idx < got_q.size()) return got_q[idx].data[127:96];
        else return 32'hXXXX_XXXX;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 128'h0;
        s_axis.tkeep  = 16'h0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 32'h0;
        cfg_dst_mac   = 48'h0211_2233_4455;
        cfg_src_mac   = 48'h0A66_7788_99AA;
        repeat (3) @(posedge clk);
        #1;
        check(m_axis.tvalid == 1'b0, "rst_tvalid", 145'(m_axis.tvalid), 145'd0);
        check(m_axis.tlast == 1'b0 && m_axis.tdata == 128'h0 && m_axis.tkeep == 16'h0, "rst_data",
              {m_axis.tdata, m_axis.tkeep, m_axis.tlast}, 145'd0);
        check(s_axis.tready == 1'b0, "rst_tready", 145'(s_axis.tready), 145'd0);
        check(sent_frames == 32'd0, "rst_sent", 145'(sent_frames), 145'd0);
        rst = 1'b0;

        // Single-beat frame.
        got_q.delete();
        send_frame(1, -1, 16'h0, 1'b1, 32'hDEADBEEF, 0);
        wait_drain();
        check(got_q.size() == 3, "t1_beats", 145'(got_q.size()), 145'd3);
        if (got_q.size() == 3) begin
            check(got_q[0].data[7:0] == 8'h02 && got_q[0].data[55:48] == 8'h0A, "t1_mac_byte0",
                  145'(got_q[0].data[55:0]), 145'h0A_0000_0000_0002);
            check(got_q[0].data[111:96] == 16'hB588, "t1_ethertype", 145'(got_q[0].data[111:96]), 145'hB588);
            check(got_q[1].data[95:64] == 32'hEFBEADDE, "t1_rollover", 145'(got_q[1].data[95:64]), 145'hEFBEADDE);
            check(got_q[1].data[127:96] == 32'h0, "t1_seq0", 145'(got_q[1].data[127:96]), 145'h0);
            check(got_q[2].last && !got_q[1].last, "t1_tlast", {got_q[1].last, got_q[2].last}, 145'b01);
        end

        // 150 back-to-back beats split by the length limit; seq continues at 1.
        got_q.delete();
        send_frame(150, -1, 16'h0, 1'b1, 32'h1234_5678, 0);
        wait_drain();
        check(got_q.size() == 156, "t2_beats", 145'(got_q.size()), 145'd156);
        if (got_q.size() == 156) begin
            check(got_q[65].last && !got_q[64].last && got_q[131].last && got_q[155].last, "t2_frame_ends",
                  {got_q[64].last, got_q[65].last, got_q[131].last, got_q[155].last}, 145'b0111);
            check(seq_field(1) == 32'h0100_0000 && seq_field(67) == 32'h0200_0000 && seq_field(133) == 32'h0300_0000,
                  "t2_seqs", {seq_field(1), seq_field(67), seq_field(133)}, 145'h01000000_02000000_03000000);
        end

        // Partial keep on beat 5 closes the frame; remaining beats start a new one.
        got_q.delete();
        send_frame(8, 4, 16'h00FF, 1'b1, 32'h0, 1);
        wait_drain();
        check(got_q.size() == 12, "t3_beats", 145'(got_q.size()), 145'd12);
        if (got_q.size() == 12) begin
            check(got_q[6].last && got_q[6].keep == 16'h00FF, "t3_short_end",
                  {got_q[6].keep, got_q[6].last}, {16'h00FF, 1'b1});
            check(got_q[7].data[111:96] == 16'hB588 && !got_q[7].last, "t3_new_header",
                  145'(got_q[7].data[111:96]), 145'hB588);
            check(seq_field(8) == 32'h0500_0000, "t3_seq", 145'(seq_field(8)), 145'h05000000);
        end

        // Random traffic under 30% output ready, with config changes between bursts.
        ready_pct = 30;
        for (int f = 0; f < 6; f++) begin
            int n;
            int kidx;
            n    = int'($urandom_range(80, 1));
            kidx = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            cfg_dst_mac = {16'($urandom()), $urandom()};
            cfg_src_mac = {16'($urandom()), $urandom()};
            send_frame(n, kidx, 16'h0FFF, 1'($urandom_range(1)), $urandom(), 3);
        end
        send_frame(1, -1, 16'h0, 1'b1, $urandom(), 0);
        wait_drain();
        ready_pct = 100;

        // Reset while the 10th payload beat is presented.
        send_frame(9, -1, 16'h0, 1'b0, 32'h0BAD_F00D, 0);
        s_axis.tdata  = 128'h5555;
        s_axis.tkeep  = 16'hFFFF;
        s_axis.tlast  = 1'b0;
        s_axis.tvalid = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis.tvalid = 1'b0;
        exp_q.delete();
        m_seq      = 32'd0;
        m_in_frame = 1'b0;
        m_frames   = 0;
        check(m_axis.tvalid == 1'b0, "t5_tvalid", 145'(m_axis.tvalid), 145'd0);
        check(sent_frames == 32'd0, "t5_sent", 145'(sent_frames), 145'd0);
        got_q.delete();
        send_frame(3, -1, 16'h0, 1'b1, 32'h0, 0);
        wait_drain();
        check(seq_field(1) == 32'h0, "t5_seq0", 145'(seq_field(1)), 145'h0);

        // Sequence number wrap.
        force dut.seq_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        m_seq = 32'hFFFF_FFFF;
        got_q.delete();
        send_frame(2, -1, 16'h0, 1'b1, 32'h0, 0);
        send_frame(2, -1, 16'h0, 1'b1, 32'h0, 0);
        wait_drain();
        check(seq_field(1) == 32'hFFFF_FFFF && seq_field(5) == 32'h0, "t6_wrap",
              {seq_field(1), seq_field(5)}, 145'hFFFFFFFF_00000000);

        check(exp_q.size() == 0, "leftover_expected", 145'(exp_q.size()), 145'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
